// File: rtl/sram_arbiter.sv
// Two-port round-robin arbiter and SETUP/ACCESS/DONE sequencer for a 16-bit
// asynchronous SRAM; every strobe comes from a flop, so no req reaches the pins.
module sram_arbiter #(
  parameter int WAIT_CYCLES = 2
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        req0,
  input  logic        req1,
  input  logic        we0,
  input  logic        we1,
  input  logic [1:0]  be0,
  input  logic [1:0]  be1,
  input  logic [19:0] addr0,
  input  logic [19:0] addr1,
  input  logic [15:0] wdata0,
  input  logic [15:0] wdata1,
  output logic        ack0,
  output logic        ack1,
  output logic [15:0] rdata0,
  output logic [15:0] rdata1,
  output logic        busy,
  output logic        owner,
  output logic        CE,
  output logic        UB,
  output logic        LB,
  output logic        OE,
  output logic        WE,
  output logic [19:0] ADDR,
  inout  wire  [15:0] Data
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;

  localparam logic [3:0] LOAD = 4'(WAIT_CYCLES - 1);

  state_t      state;
  logic [3:0]  cnt;
  logic        pri;
  logic        we_q;
  logic [15:0] wdata_q;
  logic        drive;

  logic        sel_port;
  logic        sel_we;
  logic [1:0]  sel_be;
  logic [19:0] sel_addr;
  logic [15:0] sel_wdata;

  // Both requesting: the pointer decides; otherwise whichever port is asking.
  always_comb begin
    sel_port  = (req0 && req1) ? pri : req1;
    sel_we    = sel_port ? we1    : we0;
    sel_be    = sel_port ? be1    : be0;
    sel_addr  = sel_port ? addr1  : addr0;
    sel_wdata = sel_port ? wdata1 : wdata0;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state  <= IDLE;
      cnt    <= 4'd0;
      pri    <= 1'b0;
      owner  <= 1'b0;
      drive  <= 1'b0;
      CE     <= 1'b1;
      UB     <= 1'b1;
      LB     <= 1'b1;
      OE     <= 1'b1;
      WE     <= 1'b1;
      ADDR   <= 20'd0;
      rdata0 <= 16'd0;
      rdata1 <= 16'd0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req0 || req1) begin
            owner   <= sel_port;
            we_q    <= sel_we;
            wdata_q <= sel_wdata;
            ADDR    <= sel_addr;
            CE      <= 1'b0;
            OE      <= sel_we;
            UB      <= sel_we ? ~sel_be[1] : 1'b0;
            LB      <= sel_we ? ~sel_be[0] : 1'b0;
            WE      <= 1'b1;
            drive   <= sel_we;
            state   <= SETUP;
          end
        end
        SETUP: begin
          cnt   <= LOAD;
          WE    <= ~we_q;
          state <= ACCESS;
        end
        ACCESS: begin
          if (cnt == 4'd0) begin
            CE    <= 1'b1;
            OE    <= 1'b1;
            WE    <= 1'b1;
            UB    <= 1'b1;
            LB    <= 1'b1;
            state <= DONE;
            if (!we_q) begin
              if (owner) rdata1 <= Data;
              else       rdata0 <= Data;
            end
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        DONE: begin
          // Write data was held through DONE for hold time; release it now.
          drive <= 1'b0;
          pri   <= ~owner;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state != IDLE);
  assign ack0 = (state == DONE) && !owner;
  assign ack1 = (state == DONE) && owner;
  assign Data = drive ? wdata_q : 16'bz;

endmodule
